back_prop: RTL and testbench

BACK_PROP -- requirements
Module: back_prop

---
 rtl/dqn_pkg.sv | 34 +++
 rtl/sat_mul_q.sv | 33 +++
 rtl/back_prop.sv | 234 +++++++++++++++++++++++
 tb/tb_back_prop.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dqn_pkg.sv
// Shared fixed-point constants, FSM state encoding and saturation helper
// for the DQN back-propagation datapath.
package dqn_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned FRAC  = 10;
    localparam int unsigned N_IN  = 9;
    localparam int unsigned N_HID = 5;
    localparam int unsigned N_OUT = 4;

    localparam logic signed [WIDTH-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [WIDTH-1:0] SAT_MIN = 16'sh8000;

    typedef logic signed [WIDTH-1:0] q_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_W3,
        S_HID,
        S_DONE
    } state_t;

    // Saturating a - b in Q6.10: the 17-bit difference is clamped to 16 bits.
    function automatic q_t sat16(input q_t a, input q_t b);
        logic [WIDTH:0] diff;
        diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        if (diff[WIDTH] != diff[WIDTH-1]) begin
            return diff[WIDTH] ? SAT_MIN : SAT_MAX;
        end
        return diff[WIDTH-1:0];
    endfunction

endpackage

// File: rtl/sat_mul_q.sv
// Saturating Q6.10 multiplier (combinational).
// Ports:
//   i_a, i_b  : signed Q6.10 operands
//   o_prod_c  : (i_a * i_i_b) >> FRAC, clamped to the 16-bit signed range
module sat_mul_q
    import dqn_pkg::*;
#(
    parameter int unsigned FRAC = dqn_pkg::FRAC
) (
    input  q_t i_a,
    input  q_t i_b,
    output q_t o_prod_c
);

    localparam int unsigned PW = 2 * WIDTH;

    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_scaled;
    logic [PW-WIDTH:0]    w_top;

    assign w_prod   = PW'(i_a) * PW'(i_b);
    assign w_scaled = w_prod >>> FRAC;
    // Result fits only when everything above the kept field is pure sign.
    assign w_top    = w_scaled[PW-1:WIDTH-1];

    always_comb begin
        o_prod_c = w_scaled[WIDTH-1:0];
        if (!((&w_top) || (~|w_top))) begin
            o_prod_c = w_scaled[PW-1] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/back_prop.sv
// One TD back-propagation update for a 9-5-4 DQN (Q6.10 fixed point).
// A single shared multiplier produces one product per cycle: five
// hidden-to-output weight deltas (W3), then five hidden deltas (HID).
// Ports:
//   clk, rst (sync, active-low), start (sampled in IDLE)
//   st, action, target, lr_shift, a3_in, a2_in, w3_in : run operands
//   deltaw3_out, deltab3_out, deltab2_out, deltaw2_row, st_out : results
//   busy (high outside IDLE), done (one-cycle pulse in DONE)
module back_prop
    import dqn_pkg::*;
#(
    parameter int unsigned FRAC  = dqn_pkg::FRAC,
    parameter int unsigned N_HID = dqn_pkg::N_HID,
    parameter int unsigned N_OUT = dqn_pkg::N_OUT,
    parameter int unsigned N_IN  = dqn_pkg::N_IN
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [3:0]                      st,
    input  logic [1:0]                      action,
    input  logic [WIDTH-1:0]                target,
    input  logic [3:0]                      lr_shift,
    input  logic [N_OUT*WIDTH-1:0]          a3_in,
    input  logic [N_HID*WIDTH-1:0]          a2_in,
    input  logic [N_HID*N_OUT*WIDTH-1:0]    w3_in,
    output logic [N_HID*N_OUT*WIDTH-1:0]    deltaw3_out,
    output logic [N_OUT*WIDTH-1:0]          deltab3_out,
    output logic [N_HID*WIDTH-1:0]          deltab2_out,
    output logic [N_HID*WIDTH-1:0]          deltaw2_row,
    output logic [3:0]                      st_out,
    output logic                            busy,
    output logic                            done
);

    localparam int unsigned CNT_W = $clog2(N_HID);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_HID - 1);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;

    // Captured operands: only the action column of w3 and a3 is ever used.
    logic [3:0]         r_st;
    logic [1:0]         r_action;
    logic [3:0]         r_lr;
    q_t                 r_target;
    q_t                 r_a3_sel;
    q_t                 r_delta3;
    q_t                 r_a2    [N_HID];
    q_t                 r_w3col [N_HID];

    logic [N_HID*N_OUT*WIDTH-1:0] r_dw3;
    logic [N_OUT*WIDTH-1:0]       r_db3;
    logic [N_HID*WIDTH-1:0]       r_db2;
    logic [N_HID*WIDTH-1:0]       r_dw2;
    logic [3:0]                   r_st_out;
    logic                         r_busy;
    logic                         r_done;

    q_t     w_a3_sel;
    q_t     w_w3col [N_HID];
    q_t     w_a2_j;
    q_t     w_w3_j;
    q_t     w_mul_a;
    q_t     w_mul_b;
    q_t     w_prod;
    q_t     w_prod_sh;
    q_t     w_delta3;
    q_t     w_db3_val;
    q_t     w_d2_sh;
    logic   w_relu;
    logic   w_st_ok;

    // Select the action column from the raw inputs for capture.
    always_comb begin
        w_a3_sel = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (action == 2'(k)) w_a3_sel = a3_in[k*WIDTH +: WIDTH];
        end
        for (int j = 0; j < N_HID; j++) begin
            w_w3col[j] = '0;
            for (int k = 0; k < N_OUT; k++) begin
                if (action == 2'(k)) w_w3col[j] = w3_in[(j*N_OUT+k)*WIDTH +: WIDTH];
            end
        end
    end

    // Operand routing for the shared multiplier, indexed by the step counter.
    always_comb begin
        w_a2_j = '0;
        w_w3_j = '0;
        for (int j = 0; j < N_HID; j++) begin
            if (r_cnt == CNT_W'(j)) begin
                w_a2_j = r_a2[j];
                w_w3_j = r_w3col[j];
            end
        end
        if (r_state == S_HID) begin
            w_mul_a = w_w3_j;
            w_mul_b = r_delta3;
        end else begin
            w_mul_a = r_delta3;
            w_mul_b = w_a2_j;
        end
    end

    sat_mul_q #(
        .FRAC     (FRAC)
    ) u_mul (
        .i_a      (w_mul_a),
        .i_b      (w_mul_b),
        .o_prod_c (w_prod)
    );

    assign w_delta3  = sat16(r_a3_sel, r_target);
    assign w_db3_val = w_delta3 >>> r_lr;
    assign w_prod_sh = w_prod >>> r_lr;
    // ReLU derivative: strictly positive activations pass the error back.
    assign w_relu    = !w_a2_j[WIDTH-1] && (w_a2_j != '0);
    assign w_d2_sh   = w_relu ? w_prod_sh : '0;
    assign w_st_ok   = (r_st <= 4'(N_IN - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and step counter.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = '0;
        case (r_state)
            S_IDLE: if (start) w_next = S_ERR;
            S_ERR:  w_next = S_W3;
            S_W3: begin
                if (r_cnt == CNT_LAST) w_next = S_HID;
                else                   w_cnt_next = r_cnt + CNT_W'(1);
            end
            S_HID: begin
                if (r_cnt == CNT_LAST) w_next = S_DONE;
                else                   w_cnt_next = r_cnt + CNT_W'(1);
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture and result accumulation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_st     <= '0;
            r_action <= '0;
            r_lr     <= '0;
            r_target <= '0;
            r_a3_sel <= '0;
            r_delta3 <= '0;
            for (int j = 0; j < N_HID; j++) begin
                r_a2[j]    <= '0;
                r_w3col[j] <= '0;
            end
            r_dw3    <= '0;
            r_db3    <= '0;
            r_db2    <= '0;
            r_dw2    <= '0;
            r_st_out <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_st     <= st;
                        r_action <= action;
                        r_lr     <= lr_shift;
                        r_target <= target;
                        r_a3_sel <= w_a3_sel;
                        for (int j = 0; j < N_HID; j++) begin
                            r_a2[j]    <= a2_in[j*WIDTH +: WIDTH];
                            r_w3col[j] <= w_w3col[j];
                        end
                        r_dw3    <= '0;
                        r_db3    <= '0;
                        r_db2    <= '0;
                        r_dw2    <= '0;
                        r_st_out <= st;
                    end
                end
                S_ERR: begin
                    r_delta3 <= w_delta3;
                    for (int k = 0; k < N_OUT; k++) begin
                        if (r_action == 2'(k)) r_db3[k*WIDTH +: WIDTH] <= w_db3_val;
                    end
                end
                S_W3: begin
                    for (int j = 0; j < N_HID; j++) begin
                        for (int k = 0; k < N_OUT; k++) begin
                            if (r_cnt == CNT_W'(j) && r_action == 2'(k)) begin
                                r_dw3[(j*N_OUT+k)*WIDTH +: WIDTH] <= w_prod_sh;
                            end
                        end
                    end
                end
                S_HID: begin
                    for (int j = 0; j < N_HID; j++) begin
                        if (r_cnt == CNT_W'(j)) begin
                            r_db2[j*WIDTH +: WIDTH] <= w_d2_sh;
                            r_dw2[j*WIDTH +: WIDTH] <= w_st_ok ? w_d2_sh : '0;
                        end
                    end
                end
                default: ;
            endcase
            r_busy <= (w_next != S_IDLE);
            r_done <= (w_next == S_DONE);
        end
    end

    assign deltaw3_out = r_dw3;
    assign deltab3_out = r_db3;
    assign deltab2_out = r_db2;
    assign deltaw2_row = r_dw2;
    assign st_out      = r_st_out;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_back_prop.sv
// Scoreboard bench for back_prop: each run pushes a model result when it is
// launched; the result is popped and compared when done is seen.
module tb_back_prop;

    logic         clk;
    logic         rst;
    logic         start;
    logic [3:0]   st;
    logic [1:0]   action;
    logic [15:0]  target;
    logic [3:0]   lr_shift;
    logic [63:0]  a3_in;
    logic [79:0]  a2_in;
    logic [319:0] w3_in;
    logic [319:0] deltaw3_out;
    logic [63:0]  deltab3_out;
    logic [79:0]  deltab2_out;
    logic [79:0]  deltaw2_row;
    logic [3:0]   st_out;
    logic         busy;
    logic         done;

    back_prop dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .st          (st),
        .action      (action),
        .target      (target),
        .lr_shift    (lr_shift),
        .a3_in       (a3_in),
        .a2_in       (a2_in),
        .w3_in       (w3_in),
        .deltaw3_out (deltaw3_out),
        .deltab3_out (deltab3_out),
        .deltab2_out (deltab2_out),
        .deltaw2_row (deltaw2_row),
        .st_out      (st_out),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   st;
        logic [1:0]   action;
        logic [15:0]  target;
        logic [3:0]   lr;
        logic [63:0]  a3;
        logic [79:0]  a2;
        logic [319:0] w3;
    } stim_t;

    typedef struct {
        logic [319:0] dw3;
        logic [63:0]  db3;
        logic [79:0]  db2;
        logic [79:0]  dw2;
        logic [3:0]   st_out;
    } res_t;

    res_t exp_q[$];
    int   vecs = 0;
    int   errs = 0;

    // ---------------- reference model ----------------
    function automatic int s16(input logic [15:0] x);
        return int'($signed(x));
    endfunction

    function automatic int clamp16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic int qmul(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        return clamp16(p >>> 10);
    endfunction

    function automatic res_t model(input stim_t s);
        res_t r;
        int   act, d3, a2j, w3j, d2;
        act = int'(s.action);
        r.dw3 = '0; r.db3 = '0; r.db2 = '0; r.dw2 = '0;
        r.st_out = s.st;
        d3 = clamp16(longint'(s16(s.a3[act*16 +: 16])) - longint'(s16(s.target)));
        r.db3[act*16 +: 16] = 16'(d3 >>> s.lr);
        for (int j = 0; j < 5; j++) begin
            a2j = s16(s.a2[j*16 +: 16]);
            w3j = s16(s.w3[(4*j+act)*16 +: 16]);
            r.dw3[(4*j+act)*16 +: 16] = 16'(qmul(d3, a2j) >>> s.lr);
            d2 = (a2j > 0) ? qmul(w3j, d3) : 0;
            r.db2[j*16 +: 16] = 16'(d2 >>> s.lr);
            r.dw2[j*16 +: 16] = (s.st > 4'd8) ? 16'h0000 : 16'(d2 >>> s.lr);
        end
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic stim_t rand_stim();
        stim_t s;
        s.st     = 4'($urandom_range(0, 15));
        s.action = 2'($urandom_range(0, 3));
        s.target = 16'($urandom());
        s.lr     = 4'($urandom_range(0, 15));
        s.a3     = {$urandom(), $urandom()};
        s.a2     = {16'($urandom()), $urandom(), $urandom()};
        for (int i = 0; i < 10; i++) s.w3[i*32 +: 32] = $urandom();
        return s;
    endfunction

    function automatic stim_t nominal_stim();
        stim_t s;
        s.st = 4'd3; s.action = 2'd1; s.target = 16'h0400; s.lr = 4'd0;
        s.a3 = {16'h0100, 16'h0300, 16'h0800, 16'h0123};
        s.a2 = {5{16'h0400}};
        for (int j = 0; j < 5; j++) begin
            s.w3[(4*j)*16 +: 64] = {16'h0333, 16'h0111, 16'h0200, 16'h0555};
        end
        return s;
    endfunction

    task automatic drive(input stim_t s);
        st = s.st; action = s.action; target = s.target; lr_shift = s.lr;
        a3_in = s.a3; a2_in = s.a2; w3_in = s.w3;
    endtask

    // Launch one run, scramble inputs, optionally pulse start at cycles p1/p2
    // of the run (cycle 1 = first cycle after acceptance), wait for done,
    // then watch four idle cycles for spurious activity or output drift.
    task automatic do_run(input stim_t s, input int p1, input int p2,
                          output res_t o, output int lat, output int proto);
        int c;
        exp_q.push_back(model(s));
        o.dw3 = '0; o.db3 = '0; o.db2 = '0; o.dw2 = '0; o.st_out = '0;
        lat = 0; proto = 0;
        @(posedge clk); #1;
        drive(s);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drive(rand_stim());
        c = 1;
        while (c <= 40 && lat == 0) begin
            start = (c == p1 || c == p2);
            if (!busy) proto++;
            if (done) begin
                lat = c;
                o.dw3 = deltaw3_out; o.db3 = deltab3_out; o.db2 = deltab2_out;
                o.dw2 = deltaw2_row; o.st_out = st_out;
            end else begin
                @(posedge clk); #1;
                c++;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done || busy) proto++;
            if (deltaw3_out !== o.dw3 || deltab3_out !== o.db3 ||
                deltab2_out !== o.db2 || deltaw2_row !== o.dw2) proto++;
            @(posedge clk); #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(rand_stim());
        rst = 1'b0; start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0; rst = 1'b1;
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
        vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", done); end
        vecs++; if (deltaw3_out !== '0 || deltab3_out !== '0) begin
            errs++; $display("FAIL reset_delta3 got dw3=%h db3=%h want 0", deltaw3_out, deltab3_out);
        end
        vecs++; if (deltab2_out !== '0 || deltaw2_row !== '0 || st_out !== '0) begin
            errs++; $display("FAIL reset_delta2 got db2=%h dw2=%h st=%h want 0", deltab2_out, deltaw2_row, st_out);
        end
    endtask

    task automatic test_nominal();
        res_t o, e; int lat, pe;
        do_run(nominal_stim(), 0, 0, o, lat, pe);
        e = exp_q.pop_front();
        vecs++; if (lat !== 12) begin errs++; $display("FAIL nominal_latency got %0d want 12", lat); end
        vecs++; if (o.db3 !== 64'h0000_0000_0400_0000) begin errs++; $display("FAIL nominal_db3 got %h want 0000000004000000", o.db3); end
        vecs++; if (o.dw2 !== 80'h0200_0200_0200_0200_0200) begin errs++; $display("FAIL nominal_dw2 got %h want 02000200020002000200", o.dw2); end
        vecs++; if (o.dw3 !== e.dw3) begin errs++; $display("FAIL nominal_dw3 got %h want %h", o.dw3, e.dw3); end
        vecs++; if (o.db2 !== e.db2) begin errs++; $display("FAIL nominal_db2 got %h want %h", o.db2, e.db2); end
        vecs++; if (o.st_out !== 4'd3) begin errs++; $display("FAIL nominal_st_out got %0d want 3", o.st_out); end
        vecs++; if (pe !== 0) begin errs++; $display("FAIL nominal_protocol got %0d want 0", pe); end
    endtask

    task automatic test_lr_shift();
        stim_t s; res_t o, e; int lat, pe;
        s = nominal_stim();
        s.lr = 4'd2;
        s.a2[3*16 +: 16] = 16'hFC00;
        do_run(s, 0, 0, o, lat, pe);
        e = exp_q.pop_front();
        vecs++; if (lat !== 12) begin errs++; $display("FAIL lr_latency got %0d want 12", lat); end
        vecs++; if (o.db3 !== 64'h0000_0000_0100_0000) begin errs++; $display("FAIL lr_db3 got %h want 0000000001000000", o.db3); end
        vecs++; if (o.db2 !== 80'h0080_0000_0080_0080_0080) begin errs++; $display("FAIL lr_db2 got %h want 00800000008000800080", o.db2); end
        vecs++; if (o.dw3 !== e.dw3) begin errs++; $display("FAIL lr_dw3 got %h want %h", o.dw3, e.dw3); end
        vecs++; if (o.dw2 !== e.dw2) begin errs++; $display("FAIL lr_dw2 got %h want %h", o.dw2, e.dw2); end
    endtask

    task automatic test_saturation();
        stim_t s; res_t o, e; int lat, pe;
        s = nominal_stim();
        s.action = 2'd0; s.target = 16'h8000; s.st = 4'd0;
        s.a3[15:0] = 16'h7FFF;
        s.a2 = {5{16'h7FFF}};
        for (int j = 0; j < 5; j++) s.w3[(4*j)*16 +: 16] = 16'h4000;
        s.w3[(4*2)*16 +: 16] = 16'hC000;
        do_run(s, 0, 0, o, lat, pe);
        e = exp_q.pop_front();
        vecs++; if (o.db3 !== 64'h0000_0000_0000_7FFF) begin errs++; $display("FAIL sat_db3 got %h want 0000000000007fff", o.db3); end
        vecs++; if (o.dw3[15:0] !== 16'h7FFF) begin errs++; $display("FAIL sat_dw3_11 got %h want 7fff", o.dw3[15:0]); end
        vecs++; if (o.db2 !== 80'h7FFF_7FFF_8000_7FFF_7FFF) begin errs++; $display("FAIL sat_db2 got %h want 7fff7fff80007fff7fff", o.db2); end
        vecs++; if (o.dw3 !== e.dw3) begin errs++; $display("FAIL sat_dw3 got %h want %h", o.dw3, e.dw3); end
    endtask

    task automatic test_protocol();
        stim_t s; res_t o, e; int lat, pe;
        s = nominal_stim();
        s.st = 4'd12;
        do_run(s, 3, 8, o, lat, pe);
        e = exp_q.pop_front();
        vecs++; if (lat !== 12) begin errs++; $display("FAIL proto_latency got %0d want 12", lat); end
        vecs++; if (pe !== 0) begin errs++; $display("FAIL proto_busy_start got %0d extra events want 0", pe); end
        vecs++; if (o.dw2 !== 80'h0) begin errs++; $display("FAIL proto_dw2_st12 got %h want 0", o.dw2); end
        vecs++; if (o.db2 !== e.db2 || o.dw3 !== e.dw3) begin
            errs++; $display("FAIL proto_results got db2=%h dw3=%h want db2=%h dw3=%h", o.db2, o.dw3, e.db2, e.dw3);
        end
        vecs++; if (o.st_out !== 4'd12) begin errs++; $display("FAIL proto_st_out got %0d want 12", o.st_out); end
        // start raised in the done cycle must not be accepted.
        s = rand_stim();
        do_run(s, 12, 0, o, lat, pe);
        e = exp_q.pop_front();
        vecs++; if (pe !== 0) begin errs++; $display("FAIL proto_done_start got %0d extra events want 0", pe); end
        vecs++; if (o.db3 !== e.db3 || o.dw2 !== e.dw2) begin
            errs++; $display("FAIL proto_done_results got db3=%h dw2=%h want db3=%h dw2=%h", o.db3, o.dw2, e.db3, e.dw2);
        end
    endtask

    task automatic test_midrun_reset();
        res_t o, e; int lat, pe;
        @(posedge clk); #1;
        drive(nominal_stim());
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL midrun_busy_before got %b want 1", busy); end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        vecs++; if (busy !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL midrun_ctrl got busy=%b done=%b want 0 0", busy, done); end
        vecs++; if (deltaw3_out !== '0 || deltab3_out !== '0 || deltab2_out !== '0 ||
                    deltaw2_row !== '0 || st_out !== '0) begin
            errs++; $display("FAIL midrun_outputs got dw3=%h db3=%h db2=%h dw2=%h st=%h want 0",
                             deltaw3_out, deltab3_out, deltab2_out, deltaw2_row, st_out);
        end
        repeat (3) @(posedge clk);
        #1;
        vecs++; if (busy !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL midrun_idle got busy=%b done=%b want 0 0", busy, done); end
        do_run(nominal_stim(), 0, 0, o, lat, pe);
        e = exp_q.pop_front();
        vecs++; if (lat !== 12) begin errs++; $display("FAIL midrun_rerun_latency got %0d want 12", lat); end
        vecs++; if (o.dw3 !== e.dw3 || o.db3 !== e.db3 || o.db2 !== e.db2 || o.dw2 !== e.dw2) begin
            errs++; $display("FAIL midrun_rerun_results got dw3=%h db2=%h want dw3=%h db2=%h", o.dw3, o.db2, e.dw3, e.db2);
        end
    endtask

    task automatic test_back_to_back();
        res_t o, e; int lat, pe;
        for (int n = 0; n < 8; n++) begin
            do_run(rand_stim(), 0, 0, o, lat, pe);
            e = exp_q.pop_front();
            vecs++; if (lat !== 12 || pe !== 0) begin
                errs++; $display("FAIL b2b%0d_timing got lat=%0d proto=%0d want 12 0", n, lat, pe);
            end
            vecs++; if (o.dw3 !== e.dw3) begin errs++; $display("FAIL b2b%0d_dw3 got %h want %h", n, o.dw3, e.dw3); end
            vecs++; if (o.db3 !== e.db3) begin errs++; $display("FAIL b2b%0d_db3 got %h want %h", n, o.db3, e.db3); end
            vecs++; if (o.db2 !== e.db2 || o.dw2 !== e.dw2) begin
                errs++; $display("FAIL b2b%0d_hid got db2=%h dw2=%h want db2=%h dw2=%h", n, o.db2, o.dw2, e.db2, e.dw2);
            end
            vecs++; if (o.st_out !== e.st_out) begin errs++; $display("FAIL b2b%0d_st got %h want %h", n, o.st_out, e.st_out); end
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0;
        st = '0; action = '0; target = '0; lr_shift = '0;
        a3_in = '0; a2_in = '0; w3_in = '0;
        test_reset();
        test_nominal();
        test_lr_shift();
        test_saturation();
        test_protocol();
        test_midrun_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
